// File: rtl/snake_pkg.sv
// Shared types and constants for the snake movement controller.
// Holds heading and FSM encodings, segment field positions and the reversal test.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_CALC  = 3'd2,
    S_SHIFT = 3'd3,
    S_HEAD  = 3'd4,
    S_DEAD  = 3'd5
  } state_t;

  localparam int SEG_X_LSB = 0;
  localparam int SEG_Y_LSB = 16;

  // Opposite headings differ only in the upper encoding bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational new-head calculation: one step along the heading,
// wrapping at the grid edges.
module snake_next_head
  import snake_pkg::*;
(
  input  logic [31:0] head,
  input  dir_t        heading,
  input  logic [15:0] grid_w,
  input  logic [15:0] grid_h,
  output logic [31:0] next_head
);

  logic [15:0] x_s;
  logic [15:0] y_s;
  logic [15:0] nx_s;
  logic [15:0] ny_s;

  // Step one cell in the heading direction with toroidal wrap.
  always_comb begin
    x_s  = head[SEG_X_LSB +: 16];
    y_s  = head[SEG_Y_LSB +: 16];
    nx_s = x_s;
    ny_s = y_s;
    case (heading)
      DIR_UP:    ny_s = (y_s == 16'd0) ? grid_h - 16'd1 : y_s - 16'd1;
      DIR_RIGHT: nx_s = (x_s == grid_w - 16'd1) ? 16'd0 : x_s + 16'd1;
      DIR_DOWN:  ny_s = (y_s == grid_h - 16'd1) ? 16'd0 : y_s + 16'd1;
      DIR_LEFT:  nx_s = (x_s == 16'd0) ? grid_w - 16'd1 : x_s - 16'd1;
      default: begin
        nx_s = x_s;
        ny_s = y_s;
      end
    endcase
    next_head = 32'd0;
    next_head[SEG_X_LSB +: 16] = nx_s;
    next_head[SEG_Y_LSB +: 16] = ny_s;
  end

endmodule

// File: rtl/snake_mover.sv
// Write controller for the snake segment register file: initialises the body,
// then on each tick shifts segments toward the tail and writes the new head.
module snake_mover
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 12,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 10,
  parameter int INIT_Y   = 10,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [1:0]            dir,
  input  logic                  grow,
  input  logic [MAX_LEN*32-1:0] body_in,
  output logic [31:0]           value_out,
  output logic [31:0]           index,
  output logic                  write_en,
  output logic [3:0]            length,
  output logic                  busy,
  output logic                  step_done,
  output logic                  dead
);

  localparam logic [3:0] MAX_L  = 4'(MAX_LEN);
  localparam logic [3:0] INIT_L = 4'(INIT_LEN);

  state_t      state_r;
  dir_t        heading_r;
  logic [3:0]  length_r;
  logic [3:0]  ptr_r;
  logic [3:0]  init_cnt_r;
  logic        grow_pend_r;
  logic        g_r;
  logic        dead_r;
  logic        step_done_r;
  logic        write_en_r;
  logic        busy_r;
  logic [31:0] index_r;
  logic [31:0] value_out_r;
  logic [31:0] nh_r;

  logic [31:0] slot_s [MAX_LEN];
  logic [31:0] nh_s;
  logic [31:0] shift_src_s;
  logic [31:0] init_word_s;
  logic [3:0]  cmp_cnt_s;
  logic        hit_s;

  snake_next_head u_next_head (
    .head      (slot_s[0]),
    .heading   (heading_r),
    .grid_w    (16'(GRID_W)),
    .grid_h    (16'(GRID_H)),
    .next_head (nh_s)
  );

  // Slot unpacking, shift source select, collision scan and init word.
  always_comb begin
    cmp_cnt_s   = g_r ? length_r : length_r - 4'd1;
    hit_s       = 1'b0;
    shift_src_s = 32'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      slot_s[i]   = body_in[32*i +: 32];
      hit_s       = hit_s | ((4'(i) < cmp_cnt_s) && (slot_s[i] == nh_s));
      shift_src_s = (ptr_r == 4'(i + 1)) ? slot_s[i] : shift_src_s;
    end
    init_word_s = 32'd0;
    init_word_s[SEG_X_LSB +: 16] = 16'(INIT_X) - {12'd0, init_cnt_r};
    init_word_s[SEG_Y_LSB +: 16] = 16'(INIT_Y);
  end

  // Main FSM with registered write port and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= S_INIT;
      heading_r   <= DIR_RIGHT;
      length_r    <= INIT_L;
      ptr_r       <= 4'd0;
      init_cnt_r  <= 4'd0;
      grow_pend_r <= 1'b0;
      g_r         <= 1'b0;
      dead_r      <= 1'b0;
      step_done_r <= 1'b0;
      write_en_r  <= 1'b0;
      busy_r      <= 1'b1;
      index_r     <= 32'd0;
      value_out_r <= 32'd0;
      nh_r        <= 32'd0;
    end else begin
      write_en_r  <= 1'b0;
      step_done_r <= 1'b0;
      grow_pend_r <= grow | (grow_pend_r & ~((state_r == S_HEAD) & g_r));
      case (state_r)
        S_INIT: begin
          write_en_r  <= 1'b1;
          index_r     <= {28'd0, init_cnt_r};
          value_out_r <= init_word_s;
          if (init_cnt_r == INIT_L - 4'd1) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            init_cnt_r <= init_cnt_r + 4'd1;
          end
        end
        S_IDLE: begin
          if (tick) begin
            if (!is_reverse(dir_t'(dir), heading_r)) begin
              heading_r <= dir_t'(dir);
            end else begin
              heading_r <= heading_r;
            end
            g_r     <= grow_pend_r;
            state_r <= S_CALC;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CALC: begin
          nh_r <= nh_s;
          if (hit_s) begin
            dead_r      <= 1'b1;
            step_done_r <= 1'b1;
            state_r     <= S_DEAD;
            busy_r      <= 1'b0;
          end else if (g_r && (length_r < MAX_L)) begin
            ptr_r   <= length_r;
            state_r <= S_SHIFT;
          end else if (length_r == 4'd1) begin
            ptr_r   <= 4'd0;
            state_r <= S_HEAD;
          end else begin
            ptr_r   <= length_r - 4'd1;
            state_r <= S_SHIFT;
          end
        end
        // High-to-low order keeps each source slot intact until it has been read.
        S_SHIFT: begin
          write_en_r  <= 1'b1;
          index_r     <= {28'd0, ptr_r};
          value_out_r <= shift_src_s;
          ptr_r       <= ptr_r - 4'd1;
          if (ptr_r == 4'd1) begin
            state_r <= S_HEAD;
          end else begin
            state_r <= S_SHIFT;
          end
        end
        S_HEAD: begin
          write_en_r  <= 1'b1;
          index_r     <= 32'd0;
          value_out_r <= nh_r;
          if (g_r && (length_r < MAX_L)) begin
            length_r <= length_r + 4'd1;
          end else begin
            length_r <= length_r;
          end
          step_done_r <= 1'b1;
          state_r     <= S_IDLE;
          busy_r      <= 1'b0;
        end
        S_DEAD: begin
          state_r <= S_DEAD;
        end
        default: begin
          state_r    <= S_INIT;
          init_cnt_r <= 4'd0;
          busy_r     <= 1'b1;
        end
      endcase
    end
  end

  assign value_out = value_out_r;
  assign index     = index_r;
  assign write_en  = write_en_r;
  assign length    = length_r;
  assign busy      = busy_r;
  assign step_done = step_done_r;
  assign dead      = dead_r;

endmodule

// File: tb/tb_snake_mover.sv
// Self-checking bench for snake_mover: models the segment register file and
// predicts every step from the snake's movement rules on a queue of segments.
module tb_snake_mover;

  localparam int NSLOT = 12;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 tick = 1'b0;
  logic                 grow = 1'b0;
  logic [1:0]           dir = 2'b01;
  logic [NSLOT*32-1:0]  body_in;
  logic [31:0]          value_out;
  logic [31:0]          index;
  logic                 write_en;
  logic [3:0]           length;
  logic                 busy;
  logic                 step_done;
  logic                 dead;

  logic [31:0] mem [NSLOT] = '{default: 32'd0};
  logic        poke_en = 1'b0;
  int          poke_idx = 0;
  logic [31:0] poke_val = 32'd0;

  logic [63:0] wr_q[$];
  logic [63:0] exp_w[$];
  logic [31:0] body_q[$];
  int          m_head;
  int          m_len;
  bit          m_grow;
  bit          m_dead;
  int          checks = 0;
  int          errors = 0;

  snake_mover dut (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .dir       (dir),
    .grow      (grow),
    .body_in   (body_in),
    .value_out (value_out),
    .index     (index),
    .write_en  (write_en),
    .length    (length),
    .busy      (busy),
    .step_done (step_done),
    .dead      (dead)
  );

  always #5 clock = ~clock;

  // Segment register file plus a log of every write the DUT issues.
  always @(posedge clock) begin
    if (write_en) begin
      wr_q.push_back({index, value_out});
      if (index < 32'(NSLOT)) mem[int'(index)] <= value_out;
    end
    if (poke_en) mem[poke_idx] <= poke_val;
  end

  always_comb begin
    for (int i = 0; i < NSLOT; i++) body_in[32*i +: 32] = mem[i];
  end

  function automatic logic [31:0] pos(input int x, input int y);
    return {16'(y), 16'(x)};
  endfunction

  function automatic logic [31:0] move(input logic [31:0] h, input int d);
    int x = int'(h[15:0]);
    int y = int'(h[31:16]);
    case (d)
      0: y = y - 1;
      1: x = x + 1;
      2: y = y + 1;
      default: x = x - 1;
    endcase
    x = (x + 40) % 40;
    y = (y + 30) % 30;
    return pos(x, y);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input int base);
    chk("write_count", 64'(wr_q.size() - base), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      if (base + i < wr_q.size()) chk("write_word", wr_q[base + i], exp_w[i]);
    end
  endtask

  task automatic check_state();
    chk("length", 64'(length), 64'(m_len));
    chk("dead", 64'(dead), 64'(m_dead));
    chk("busy_idle", 64'(busy), 64'd0);
    for (int i = 0; i < m_len; i++) chk("regfile", 64'(mem[i]), 64'(body_q[i]));
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clock);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clock);
    poke_en = 1'b0;
    body_q[idx] = val;
  endtask

  task automatic pulse_grow();
    @(negedge clock); grow = 1'b1;
    @(negedge clock); grow = 1'b0;
    m_grow = 1'b1;
  endtask

  task automatic do_reset();
    int cyc;
    int base;
    @(negedge clock);
    reset = 1'b1; tick = 1'b0; grow = 1'b0;
    @(negedge clock);
    chk("rst_write_en", 64'(write_en), 64'd0);
    chk("rst_index", 64'(index), 64'd0);
    chk("rst_value", 64'(value_out), 64'd0);
    chk("rst_length", 64'(length), 64'd3);
    chk("rst_dead", 64'(dead), 64'd0);
    chk("rst_step_done", 64'(step_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    base = wr_q.size();
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("init_cycles", 64'(cyc), 64'd3);
    @(negedge clock);
    body_q = {pos(10, 10), pos(9, 10), pos(8, 10)};
    m_head = 1; m_len = 3; m_grow = 1'b0; m_dead = 1'b0;
    exp_w.delete();
    for (int i = 0; i < 3; i++) exp_w.push_back({32'(i), body_q[i]});
    check_writes(base);
    check_state();
  endtask

  task automatic do_step(input int d, input bit extra);
    int hd_new, newlen, lat, cyc, base, lim;
    logic [31:0] nh;
    bit hit, g, saw;
    base = wr_q.size();
    if (m_dead) begin
      @(negedge clock); tick = 1'b1; dir = 2'(d);
      @(negedge clock); tick = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clock);
        saw = saw | step_done;
      end
      chk("dead_no_step", 64'(saw), 64'd0);
      chk("dead_no_write", 64'(wr_q.size() - base), 64'd0);
      chk("dead_sticky", 64'(dead), 64'd1);
    end else begin
      hd_new = ((d ^ m_head) == 2) ? m_head : d;
      g = m_grow;
      nh = move(body_q[0], hd_new);
      lim = g ? m_len : m_len - 1;
      hit = 1'b0;
      for (int i = 0; i < lim; i++) hit = hit | (body_q[i] == nh);
      newlen = (!hit && g) ? ((m_len < NSLOT) ? m_len + 1 : NSLOT) : m_len;
      exp_w.delete();
      if (!hit) begin
        for (int idx = newlen - 1; idx >= 1; idx--) exp_w.push_back({32'(idx), body_q[idx-1]});
        exp_w.push_back({32'd0, nh});
      end
      lat = hit ? 2 : 2 + newlen;
      @(negedge clock); tick = 1'b1; dir = 2'(d);
      @(negedge clock); tick = 1'b0;
      cyc = 1;
      while (!step_done && cyc < 60) begin
        @(negedge clock);
        cyc++;
        tick = extra && (cyc == 3);
      end
      tick = 1'b0;
      chk("step_done_seen", 64'(step_done), 64'd1);
      chk("latency", 64'(cyc), 64'(lat));
      m_head = hd_new;
      if (hit) begin
        m_dead = 1'b1;
      end else begin
        if (g) m_grow = 1'b0;
        body_q.push_front(nh);
        while (body_q.size() > newlen) void'(body_q.pop_back());
        m_len = newlen;
      end
      @(negedge clock);
      @(negedge clock);
      chk("step_done_pulse", 64'(step_done), 64'd0);
      check_writes(base);
      check_state();
    end
  endtask

  initial begin
    do_reset();

    // Basic move, growth, wrap in x and y, rejected reversal with a dropped tick.
    do_step(1, 1'b0);
    pulse_grow();
    do_step(2, 1'b0);
    poke(0, pos(39, 5));
    do_step(1, 1'b0);
    poke(0, pos(7, 0));
    do_step(0, 1'b0);
    do_step(1, 1'b0);
    do_step(3, 1'b1);

    // Head steps onto slot 2 of a length-4 body.
    poke(0, pos(5, 5));
    poke(1, pos(5, 6));
    poke(2, pos(6, 5));
    poke(3, pos(7, 5));
    do_step(1, 1'b0);
    chk("collide_dead", 64'(m_dead), 64'd1);
    do_step(1, 1'b0);
    do_reset();

    // Grow past the slot limit.
    for (int i = 0; i < 10; i++) begin
      pulse_grow();
      do_step(1, 1'b0);
    end
    chk("len_capped", 64'(length), 64'd12);
    do_step(1, 1'b0);

    // Reset in the middle of the shift phase.
    @(negedge clock); tick = 1'b1; dir = 2'b01;
    @(negedge clock); tick = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midshift_write_en", 64'(write_en), 64'd0);
    chk("midshift_busy", 64'(busy), 64'd1);
    do_reset();

    // Random walk with occasional growth.
    for (int i = 0; i < 25; i++) begin
      if (!m_dead && $urandom_range(0, 2) == 0) pulse_grow();
      do_step(int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
